time_digit_encoder: RTL and testbench

Converts the binary clock time (hours/minutes/seconds) into the eight 8-bit digit words consumed by the 8-digit display driver. It is the writer side of the d1..d8 interface. Each field is converted with a sequential shift-add-3 (double-dabble) engine, one field at a time, and all eight words are published atomically. In config mode, the selected field's digits blink under a slow tick.

---
 rtl/time_digit_encoder.sv | 211 +++++++++++++++++++++
 tb/tb_time_digit_encoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_digit_encoder.sv
// Converts binary HH:MM:SS into eight display digit words with one shared double-dabble engine.
// All six time digits are published in the same edge; the selected config field blinks.
module time_digit_encoder #(
    parameter int DP_SEP       = 1,
    parameter int BLANK_UNUSED = 1,
    parameter int HOURS_MAX    = 23
) (
    input  logic       clk_100MHz_i,
    input  logic       reset_i,
    input  logic       update_i,
    input  logic [5:0] seconds_i,
    input  logic [5:0] minutes_i,
    input  logic [4:0] hours_i,
    input  logic [1:0] sel_i,
    input  logic       blink_tick_i,
    output logic [7:0] d1,
    output logic [7:0] d2,
    output logic [7:0] d3,
    output logic [7:0] d4,
    output logic [7:0] d5,
    output logic [7:0] d6,
    output logic [7:0] d7,
    output logic [7:0] d8,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [5:0] HOURS_LIM   = 6'(HOURS_MAX);
    localparam logic       DP_BIT      = (DP_SEP != 0);
    localparam logic [7:0] UNUSED_WORD = (BLANK_UNUSED != 0) ? 8'h00 : 8'h80;

    typedef enum logic [1:0] {IDLE, SHIFT, STORE, PUBLISH} state_t;

    state_t          state;
    state_t          next_state;
    logic            start_conv;

    logic [5:0]      snap_sec;
    logic [5:0]      snap_min;
    logic [4:0]      snap_hr;

    // {tens, units, binary}; the binary part shifts up into the BCD nibbles
    logic [13:0]     shreg;
    logic [13:0]     shifted;
    logic [3:0]      adj_units;
    logic [3:0]      adj_tens;
    logic [2:0]      shift_cnt;
    logic [1:0]      field;
    logic            pending;
    logic            field_oor;
    logic [3:0]      store_tens;
    logic [3:0]      store_units;

    logic [5:0][3:0] buf_dig;
    logic [5:0][3:0] out_dig;
    logic            done_q;

    logic            phase;
    logic [1:0]      sel_q;
    logic [5:0]      en_q;
    logic [5:0]      en_next;

    always_ff @(posedge clk_100MHz_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start_conv = 1'b0;
        case (state)
            IDLE: begin
                if (update_i) begin
                    start_conv = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_cnt == 3'd1) begin
                    next_state = STORE;
                end
            end
            STORE: begin
                next_state = (field == 2'd2) ? PUBLISH : SHIFT;
            end
            PUBLISH: begin
                if (pending || update_i) begin
                    start_conv = 1'b1;
                    next_state = SHIFT;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        adj_units = (shreg[9:6] >= 4'd5) ? shreg[9:6] + 4'd3 : shreg[9:6];
        adj_tens  = (shreg[13:10] >= 4'd5) ? shreg[13:10] + 4'd3 : shreg[13:10];
        shifted   = {adj_tens[2:0], adj_units, shreg[5:0], 1'b0};

        case (field)
            2'd0:    field_oor = (snap_sec > 6'd59);
            2'd1:    field_oor = (snap_min > 6'd59);
            default: field_oor = ({1'b0, snap_hr} > HOURS_LIM);
        endcase
        store_tens  = field_oor ? 4'hE : shreg[13:10];
        store_units = field_oor ? 4'hE : shreg[9:6];
    end

    always_ff @(posedge clk_100MHz_i) begin
        if (!reset_i) begin
            snap_sec  <= '0;
            snap_min  <= '0;
            snap_hr   <= '0;
            shreg     <= '0;
            shift_cnt <= '0;
            field     <= '0;
            pending   <= 1'b0;
            buf_dig   <= '0;
            out_dig   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state == PUBLISH);

            if (start_conv) begin
                snap_sec  <= seconds_i;
                snap_min  <= minutes_i;
                snap_hr   <= hours_i;
                shreg     <= {8'd0, seconds_i};
                shift_cnt <= 3'd6;
                field     <= 2'd0;
            end else begin
                case (state)
                    SHIFT: begin
                        shreg     <= shifted;
                        shift_cnt <= shift_cnt - 3'd1;
                    end
                    STORE: begin
                        case (field)
                            2'd0:    begin buf_dig[1] <= store_tens; buf_dig[0] <= store_units; end
                            2'd1:    begin buf_dig[3] <= store_tens; buf_dig[2] <= store_units; end
                            default: begin buf_dig[5] <= store_tens; buf_dig[4] <= store_units; end
                        endcase
                        if (field != 2'd2) begin
                            field     <= field + 2'd1;
                            shreg     <= {8'd0, (field == 2'd0) ? snap_min : {1'b0, snap_hr}};
                            shift_cnt <= 3'd6;
                        end
                    end
                    default: ;
                endcase
            end

            // A request arriving in the publish cycle is consumed by the restart there
            if (state == PUBLISH) begin
                pending <= 1'b0;
            end else if (state != IDLE && update_i) begin
                pending <= 1'b1;
            end

            if (state == PUBLISH) begin
                out_dig <= buf_dig;
            end
        end
    end

    always_comb begin
        en_next = 6'b111111;
        case (sel_q)
            2'd1:    en_next[5:4] = {phase, phase};
            2'd2:    en_next[3:2] = {phase, phase};
            2'd3:    en_next[1:0] = {phase, phase};
            default: ;
        endcase
    end

    // Enables use the registered select so a field switch never blanks the new field early
    always_ff @(posedge clk_100MHz_i) begin
        if (!reset_i) begin
            phase <= 1'b1;
            sel_q <= 2'd0;
            en_q  <= 6'b111111;
        end else begin
            sel_q <= sel_i;
            if (sel_i != sel_q || sel_i == 2'd0) begin
                phase <= 1'b1;
            end else if (blink_tick_i) begin
                phase <= ~phase;
            end
            en_q <= en_next;
        end
    end

    assign d1 = {en_q[0], 2'b00, out_dig[0], 1'b0};
    assign d2 = {en_q[1], 2'b00, out_dig[1], 1'b0};
    assign d3 = {en_q[2], 2'b00, out_dig[2], DP_BIT};
    assign d4 = {en_q[3], 2'b00, out_dig[3], 1'b0};
    assign d5 = {en_q[4], 2'b00, out_dig[4], DP_BIT};
    assign d6 = {en_q[5], 2'b00, out_dig[5], 1'b0};
    assign d7 = UNUSED_WORD;
    assign d8 = UNUSED_WORD;

    assign busy_o = (state != IDLE);
    assign done_o = done_q;

endmodule

// File: tb/tb_time_digit_encoder.sv
// Bench for time_digit_encoder: table vectors, random times against an arithmetic model,
// and hand-written sequences for back-to-back requests, blinking and mid-conversion reset.
module tb_time_digit_encoder;

    localparam int DP_SEP       = 1;
    localparam int BLANK_UNUSED = 1;
    localparam int HOURS_MAX    = 23;
    localparam logic [63:0] RESET_WORDS = 64'h0000_8081_8081_8080;

    logic       clk_100MHz_i = 1'b0;
    logic       reset_i      = 1'b0;
    logic       update_i     = 1'b0;
    logic [5:0] seconds_i    = '0;
    logic [5:0] minutes_i    = '0;
    logic [4:0] hours_i      = '0;
    logic [1:0] sel_i        = '0;
    logic       blink_tick_i = 1'b0;
    logic [7:0] d1, d2, d3, d4, d5, d6, d7, d8;
    logic       busy_o;
    logic       done_o;

    int n_checks = 0;
    int n_fail   = 0;

    time_digit_encoder #(
        .DP_SEP      (DP_SEP),
        .BLANK_UNUSED(BLANK_UNUSED),
        .HOURS_MAX   (HOURS_MAX)
    ) dut (
        .clk_100MHz_i(clk_100MHz_i),
        .reset_i     (reset_i),
        .update_i    (update_i),
        .seconds_i   (seconds_i),
        .minutes_i   (minutes_i),
        .hours_i     (hours_i),
        .sel_i       (sel_i),
        .blink_tick_i(blink_tick_i),
        .d1          (d1),
        .d2          (d2),
        .d3          (d3),
        .d4          (d4),
        .d5          (d5),
        .d6          (d6),
        .d7          (d7),
        .d8          (d8),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_100MHz_i = ~clk_100MHz_i;

    typedef struct {
        int          s;
        int          m;
        int          h;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [63:0] dut_words();
        return {d8, d7, d6, d5, d4, d3, d2, d1};
    endfunction

    // Expected words from decimal arithmetic: units = v % 10, tens = v / 10
    function automatic logic [63:0] model_words(int s, int m, int h);
        int          vals[3];
        int          lims[3];
        logic [3:0]  dig[6];
        logic        dp;
        logic [63:0] w;
        vals[0] = s; vals[1] = m; vals[2] = h;
        lims[0] = 59; lims[1] = 59; lims[2] = HOURS_MAX;
        for (int f = 0; f < 3; f++) begin
            if (vals[f] > lims[f]) begin
                dig[2*f]   = 4'hE;
                dig[2*f+1] = 4'hE;
            end else begin
                dig[2*f]   = 4'(vals[f] % 10);
                dig[2*f+1] = 4'(vals[f] / 10);
            end
        end
        w = '0;
        for (int i = 0; i < 6; i++) begin
            dp = (i == 2 || i == 4) && (DP_SEP != 0);
            w[i*8 +: 8] = {1'b1, 2'b00, dig[i], dp};
        end
        w[63:48] = (BLANK_UNUSED != 0) ? 16'h0000 : 16'h8080;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk_100MHz_i);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Presents a time and a one-cycle update; returns just after the capturing edge
    task automatic apply_stimulus(input int s, input int m, input int h);
        seconds_i = 6'(s);
        minutes_i = 6'(m);
        hours_i   = 5'(h);
        update_i  = 1'b1;
        tick();
        update_i  = 1'b0;
    endtask

    task automatic convert_and_check(input string name, input int s, input int m, input int h,
                                     input logic [63:0] expected);
        int lat;
        bit busy_ok;
        apply_stimulus(s, m, h);
        lat     = 0;
        busy_ok = 1'b1;
        while (!done_o && lat < 40) begin
            if (!busy_o) busy_ok = 1'b0;
            tick();
            lat++;
        end
        check_output({name, " latency"}, 64'(lat), 64'd22);
        check_output({name, " busy held"}, 64'(busy_ok), 64'd1);
        check_output({name, " busy at done"}, 64'(busy_o), 64'd0);
        check_output({name, " words"}, dut_words(), expected);
        tick();
        check_output({name, " done width"}, 64'(done_o), 64'd0);
    endtask

    initial begin
        int          done_cnt;
        int          done_at[2];
        bit          busy_drop;
        logic        exp_phase;
        logic [63:0] last_words;
        int          s, m, h;

        vecs[0] = '{s: 7,  m: 45, h: 13, exp: 64'h0000_8287_888B_808E};
        vecs[1] = '{s: 59, m: 59, h: 23, exp: 64'h0000_8487_8A93_8A92};
        vecs[2] = '{s: 0,  m: 0,  h: 0,  exp: 64'h0000_8081_8081_8080};
        vecs[3] = '{s: 63, m: 60, h: 24, exp: 64'h0000_9C9D_9C9D_9C9C};
        vecs[4] = '{s: 10, m: 5,  h: 9,  exp: 64'h0000_8093_808B_8280};

        reset_i = 1'b0;
        repeat (3) tick();
        reset_i = 1'b1;
        check_output("reset words", dut_words(), RESET_WORDS);
        check_output("reset busy", 64'(busy_o), 64'd0);
        check_output("reset done", 64'(done_o), 64'd0);

        for (int i = 0; i < 5; i++) begin
            convert_and_check($sformatf("vec%0d", i), vecs[i].s, vecs[i].m, vecs[i].h, vecs[i].exp);
        end

        for (int i = 0; i < 16; i++) begin
            s = int'($urandom_range(0, 63));
            m = int'($urandom_range(0, 63));
            h = int'($urandom_range(0, 31));
            convert_and_check($sformatf("rand%0d %0d:%0d:%0d", i, h, m, s), s, m, h, model_words(s, m, h));
        end

        // Two requests during a conversion collapse into one restart using publish-edge inputs
        done_cnt  = 0;
        busy_drop = 1'b0;
        apply_stimulus(3, 2, 1);
        for (int j = 0; j < 70; j++) begin
            if (done_o) begin
                if (done_cnt < 2) done_at[done_cnt] = j;
                if (done_cnt == 0) check_output("b2b first words", dut_words(), model_words(3, 2, 1));
                if (done_cnt == 1) check_output("b2b second words", dut_words(), model_words(41, 50, 20));
                done_cnt++;
            end
            if (j < 44 && !busy_o) busy_drop = 1'b1;
            update_i = (j == 5 || j == 10);
            if (j == 5) begin
                seconds_i = 6'd41; minutes_i = 6'd50; hours_i = 5'd20;
            end
            if (j == 22) begin
                seconds_i = 6'd11; minutes_i = 6'd22; hours_i = 5'd3;
            end
            tick();
        end
        update_i = 1'b0;
        check_output("b2b done count", 64'(done_cnt), 64'd2);
        check_output("b2b first done", 64'(done_at[0]), 64'd22);
        check_output("b2b gap", 64'(done_at[1] - done_at[0]), 64'd22);
        check_output("b2b busy held", 64'(busy_drop), 64'd0);

        // Blink: field 2 (minutes) follows the phase, one cycle after each tick
        last_words = dut_words();
        sel_i = 2'd2;
        repeat (2) tick();
        check_output("sel2 steady", dut_words(), last_words);
        exp_phase = 1'b1;
        for (int t = 0; t < 4; t++) begin
            blink_tick_i = 1'b1;
            tick();
            blink_tick_i = 1'b0;
            exp_phase = ~exp_phase;
            tick();
            check_output($sformatf("blink%0d d4d3 en", t), 64'({d4[7], d3[7]}), 64'({exp_phase, exp_phase}));
            check_output($sformatf("blink%0d others en", t), 64'({d6[7], d5[7], d2[7], d1[7]}), 64'hF);
            check_output($sformatf("blink%0d d3 body", t), 64'(d3[6:0]), 64'(last_words[22:16]));
            repeat (2) tick();
        end
        blink_tick_i = 1'b1;
        tick();
        blink_tick_i = 1'b0;
        tick();
        check_output("blink hidden", 64'({d4[7], d3[7]}), 64'd0);
        sel_i = 2'd1;
        blink_tick_i = 1'b1;
        tick();
        blink_tick_i = 1'b0;
        check_output("switch d6d5 first", 64'({d6[7], d5[7]}), 64'h3);
        tick();
        check_output("switch all en", dut_words(), last_words);
        blink_tick_i = 1'b1;
        tick();
        blink_tick_i = 1'b0;
        tick();
        check_output("sel1 blink", 64'({d6[7], d5[7], d4[7], d3[7]}), 64'h3);
        sel_i = 2'd0;
        repeat (2) tick();
        check_output("sel0 restore", dut_words(), last_words);

        // Reset in the middle of a conversion discards it
        apply_stimulus(8, 9, 10);
        repeat (11) tick();
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        check_output("midreset words", dut_words(), RESET_WORDS);
        check_output("midreset busy", 64'(busy_o), 64'd0);
        done_cnt = 0;
        for (int j = 0; j < 30; j++) begin
            if (done_o) done_cnt++;
            tick();
        end
        check_output("midreset no done", 64'(done_cnt), 64'd0);
        check_output("midreset held", dut_words(), RESET_WORDS);
        convert_and_check("after reset", 30, 17, 6, model_words(30, 17, 6));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
